m_upload_serializer: RTL and testbench
======================================

// Module: m_upload_serializer
// PURPOSE
//  Parametrised message-to-flit serializer for the memory-side upload path of the
//  ring communication assist. Buffers up to DEPTH whole messages, each with its own
//  flit count, and emits them flit by flit toward the ring FIFO with head/body/tail
//  control codes. A new message can be accepted while the previous one is still draining.
// PARAMETERS
//  FLIT_W     16  width of one flit, in bits
//  MAX_FLITS  9   maximum number of flits per message
//  DEPTH      2   message buffer slots; must be a power of 2 and >= 2
//  (localparams) MSG_W = FLIT_W*MAX_FLITS; CNT_W = $clog2(MAX_FLITS); PTR_W = $clog2(DEPTH)
// PORTS
//  clk         in   1      single clock; all logic samples on its rising edge
//  rst         in   1      synchronous reset, active-high
//  msg_in      in   MSG_W  message payload; flit 0 = msg_in[MSG_W-1 -: FLIT_W]
//  msg_len     in   CNT_W  number of flits in the message minus 1
//  v_msg_in    in   1      msg_in and msg_len are valid
//  msg_in_rdy  out  1      a buffer slot is free
//  fifo_rdy    in   1      downstream ring FIFO can take a flit this cycle
//  flit_out    out  FLIT_W current flit
//  v_flit_out  out  1      flit_out is valid; a transfer occurs whenever this is high
//  ctrl_out    out  2      00 idle, 01 head, 10 body, 11 tail
//  busy        out  1      at least one message is buffered or in flight
// BEHAVIOUR
//  Reset: slots empty, pointers = 0, sel_cnt = 0. The outputs are then
//   msg_in_rdy = 1, v_flit_out = 0, ctrl_out = 00, flit_out = 0, busy = 0.
//   Reset during a message discards all buffered and partially sent messages.
//  Accept: on v_msg_in && msg_in_rdy, the payload and the length are written to slot wr_ptr,
//   and wr_ptr increments. If msg_len > MAX_FLITS-1, the stored length is clamped to MAX_FLITS-1.
//   While msg_in_rdy = 0, v_msg_in is ignored. No data is lost or overwritten.
//  msg_in_rdy = !full. It depends on registered occupancy only and has no path from fifo_rdy,
//   so a slot freed by a tail flit becomes ready on the next cycle.
//  Send: v_flit_out = !empty && fifo_rdy. It is combinational, with the same handshake as the
//   previous upload blocks. flit_out = slice sel_cnt of the head slot (flit k at
//   MSG_W-1-k*FLIT_W). When empty, flit_out = 0.
//  ctrl_out is valid only while v_flit_out is high; otherwise it is 00.
//   sel_cnt == len          -> 11 (tail). This has priority, so a single-flit message is sent as 11.
//   sel_cnt == 0 and len > 0 -> 01 (head).
//   otherwise               -> 10 (body).
//  Counter: on a transfer that is not a tail, sel_cnt increments. On a tail transfer, sel_cnt
//   is set to 0 and the slot is popped (rd_ptr increments). When fifo_rdy is low, all state holds.
//  Latency: a message accepted at edge N is eligible to output its first flit in cycle N+1.
//   Back-to-back messages run with no idle cycle: the head of message B follows the tail of
//   message A directly.
//  Simultaneous push and pop (including when full) are both legal. Occupancy stays the same;
//   the pointers wrap mod DEPTH.
//  busy = !empty.
// STRUCTURE
//  Shared package upload_pkg: CTRL_IDLE=2'b00, CTRL_HEAD=2'b01, CTRL_BODY=2'b10,
//   CTRL_TAIL=2'b11. All upload and download blocks reuse these codes.
//  Sub-module msg_slot_fifo: DEPTH x (MSG_W+CNT_W) storage, wr_ptr/rd_ptr/count,
//   full and empty flags. The top level holds sel_cnt, the slice mux and the ctrl encode.
// TESTING
//  1 Default parameters, fifo_rdy=1: 9-flit message (msg_len=8), flit k = 16'hA000+k.
//    -> 9 consecutive cycles, ctrl 01, 10 x7, 11; flit_out = A000..A008; busy drops after the tail.
//  2 msg_len=0, flit 0 = 16'h1234.
//    -> a single cycle with ctrl 11, flit 1234; then v_flit_out=0 and ctrl 00.
//  3 Push 3 messages back-to-back with fifo_rdy=0.
//    -> msg_in_rdy=0 after the 2nd; the 3rd is held by the source. Raise fifo_rdy -> msg 1 and
//       msg 2 are emitted with no gap, and msg_in_rdy returns 1 the cycle after msg 1's tail.
//  4 4-flit message, fifo_rdy toggles 1,0,1,0,...
//    -> exactly 4 transfers, each flit emitted once and in order; outputs are 00 when fifo_rdy is low.
//  5 rst asserted after 3 flits of a 9-flit message, with a second message buffered.
//    -> next cycle: busy=0, msg_in_rdy=1, v_flit_out=0. A new message then starts from flit 0 with ctrl 01.
//  6 msg_len=12 with MAX_FLITS=9; also run with FLIT_W=32, MAX_FLITS=4, DEPTH=4.
//    -> the length clamps to 9 flits. The wide configuration passes tests 1-4 with scaled values.

Source files
------------

// File: rtl/upload_pkg.sv
// -----------------------------------------------------------------------------
// upload_pkg
//  Shared definitions for the ring upload/download path. The flit control codes
//  travel with every flit on the ring, so every upload and download block must
//  agree on them.
//  Contents:
//   CTRL_IDLE / CTRL_HEAD / CTRL_BODY / CTRL_TAIL  2-bit flit control codes
// -----------------------------------------------------------------------------
package upload_pkg;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_BODY = 2'b10;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

endpackage : upload_pkg

// File: rtl/m_upload_serializer_if.sv
// -----------------------------------------------------------------------------
// m_upload_serializer_if
//  Bundle of the message-side and flit-side handshake signals of the upload
//  serializer.
//  Signals:
//   msg_in      MSG_W   message payload, flit 0 in the top FLIT_W bits
//   msg_len     CNT_W   flit count minus 1
//   v_msg_in    1       msg_in / msg_len valid
//   msg_in_rdy  1       serializer has a free message slot
//   fifo_rdy    1       ring FIFO can take a flit this cycle
//   flit_out    FLIT_W  current flit
//   v_flit_out  1       flit transfer this cycle
//   ctrl_out    2       idle / head / body / tail code
//   busy        1       at least one message buffered or in flight
//  Modports:
//   slave   the serializer itself
//   master  the environment (message source and ring FIFO)
// -----------------------------------------------------------------------------
interface m_upload_serializer_if #(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 9
);
    localparam int MSG_W = FLIT_W * MAX_FLITS;
    localparam int CNT_W = $clog2(MAX_FLITS);

    logic [MSG_W-1:0]  msg_in;
    logic [CNT_W-1:0]  msg_len;
    logic              v_msg_in;
    logic              msg_in_rdy;
    logic              fifo_rdy;
    logic [FLIT_W-1:0] flit_out;
    logic              v_flit_out;
    logic [1:0]        ctrl_out;
    logic              busy;

    modport slave (
        input  msg_in, msg_len, v_msg_in, fifo_rdy,
        output msg_in_rdy, flit_out, v_flit_out, ctrl_out, busy
    );

    modport master (
        output msg_in, msg_len, v_msg_in, fifo_rdy,
        input  msg_in_rdy, flit_out, v_flit_out, ctrl_out, busy
    );

endinterface : m_upload_serializer_if

// File: rtl/msg_slot_fifo.sv
// -----------------------------------------------------------------------------
// msg_slot_fifo
//  DEPTH-entry storage for whole messages (payload + clamped length) with
//  wr_ptr / rd_ptr / occupancy count and full / empty flags.
//  The head entry is read combinationally: the serializer must present the
//  first flit of a message in the cycle right after it was written, and the
//  head slot feeds the flit mux directly. DEPTH is small, so this maps to
//  distributed storage rather than a block RAM.
//  DEPTH must be a power of 2 (>= 2) so the pointers wrap for free.
//  Ports:
//   clk, rst   clock and synchronous active-high reset
//   push       write wr_data into slot wr_ptr (ignored when full)
//   wr_data    entry to store
//   pop        release the head slot (ignored when empty)
//   rd_data    head slot contents
//   full       all DEPTH slots occupied
//   empty      no slot occupied
// -----------------------------------------------------------------------------
module msg_slot_fifo #(
    parameter int WIDTH = 148,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Payload storage is not reset; the occupancy count alone says what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : msg_slot_fifo

// File: rtl/m_upload_serializer.sv
// -----------------------------------------------------------------------------
// m_upload_serializer
//  Message-to-flit serializer for the memory-side upload path of the ring
//  communication assist. Buffers up to DEPTH whole messages and emits them
//  flit by flit toward the ring FIFO, tagging each flit head/body/tail.
//  Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-high reset; drops all buffered messages
//   bus   m_upload_serializer_if.slave: message input handshake, flit output
//         handshake, ctrl code and busy flag
//  Parameters: FLIT_W (flit width), MAX_FLITS (flits per message),
//  DEPTH (message slots, power of 2, >= 2).
// -----------------------------------------------------------------------------
module m_upload_serializer
    import upload_pkg::*;
#(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 9,
    parameter int DEPTH     = 2
) (
    input logic                   clk,
    input logic                   rst,
    m_upload_serializer_if.slave  bus
);
    localparam int MSG_W  = FLIT_W * MAX_FLITS;
    localparam int CNT_W  = $clog2(MAX_FLITS);
    localparam int SLOT_W = MSG_W + CNT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FLITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  len_clamped;
    logic [SLOT_W-1:0] head_slot;
    logic [MSG_W-1:0]  head_msg;
    logic [CNT_W-1:0]  head_len;
    logic              full;
    logic              empty;
    logic              push;
    logic              xfer;
    logic              is_tail;
    logic              pop;
    logic [CNT_W-1:0]  sel_cnt_reg;
    logic [CNT_W-1:0]  sel_cnt_next;
    logic [FLIT_W-1:0] flits [MAX_FLITS];
    logic [FLIT_W-1:0] cur_flit;
    logic [1:0]        ctrl;

    // Oversized lengths are clamped so sel_cnt can never run past the payload.
    assign len_clamped = (bus.msg_len > LAST_IDX) ? LAST_IDX : bus.msg_len;
    assign push        = bus.v_msg_in && !full;

    msg_slot_fifo #(
        .WIDTH (SLOT_W),
        .DEPTH (DEPTH)
    ) u_slots (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({bus.msg_in, len_clamped}),
        .pop     (pop),
        .rd_data (head_slot),
        .full    (full),
        .empty   (empty)
    );

    assign head_msg = head_slot[SLOT_W-1 -: MSG_W];
    assign head_len = head_slot[CNT_W-1:0];

    // Flit k of the head message sits at MSG_W-1-k*FLIT_W.
    generate
        for (genvar gi = 0; gi < MAX_FLITS; gi++) begin : g_flit
            assign flits[gi] = head_msg[MSG_W-1-gi*FLIT_W -: FLIT_W];
        end
    endgenerate

    always_comb begin
        cur_flit = '0;
        for (int k = 0; k < MAX_FLITS; k++) begin
            if (sel_cnt_reg == CNT_W'(k)) begin
                cur_flit = flits[k];
            end
        end
    end

    assign xfer    = !empty && bus.fifo_rdy;
    assign is_tail = (sel_cnt_reg == head_len);
    assign pop     = xfer && is_tail;

    // Tail wins over head, so a single-flit message goes out as a tail.
    always_comb begin
        ctrl = CTRL_IDLE;
        if (xfer) begin
            if (is_tail) begin
                ctrl = CTRL_TAIL;
            end else if (sel_cnt_reg == '0) begin
                ctrl = CTRL_HEAD;
            end else begin
                ctrl = CTRL_BODY;
            end
        end
    end

    always_comb begin
        sel_cnt_next = sel_cnt_reg;
        if (xfer) begin
            sel_cnt_next = is_tail ? '0 : sel_cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_cnt_reg <= '0;
        end else begin
            sel_cnt_reg <= sel_cnt_next;
        end
    end

    // Readiness comes from registered occupancy only; no path from fifo_rdy.
    assign bus.msg_in_rdy = !full;
    assign bus.v_flit_out = xfer;
    assign bus.flit_out   = empty ? '0 : cur_flit;
    assign bus.ctrl_out   = ctrl;
    assign bus.busy       = !empty;

endmodule : m_upload_serializer

// File: tb/tb_m_upload_serializer.sv
// -----------------------------------------------------------------------------
// tb_m_upload_serializer
//  Directed bench for m_upload_serializer: a default configuration
//  (16-bit flits, 9 flits, 2 slots) and a wide one (32-bit flits, 4 flits,
//  4 slots) share clk and rst. Inputs change just after the falling edge,
//  outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_m_upload_serializer;
    import upload_pkg::*;

    localparam int N_MSG_W = 144;
    localparam int W_MSG_W = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    always #5 clk = ~clk;

    m_upload_serializer_if #(.FLIT_W(16), .MAX_FLITS(9)) nb ();
    m_upload_serializer_if #(.FLIT_W(32), .MAX_FLITS(4)) wb ();

    m_upload_serializer #(.FLIT_W(16), .MAX_FLITS(9), .DEPTH(2)) u_dut_n (
        .clk (clk),
        .rst (rst),
        .bus (nb.slave)
    );

    m_upload_serializer #(.FLIT_W(32), .MAX_FLITS(4), .DEPTH(4)) u_dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wb.slave)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N_MSG_W-1:0] mkn(input logic [15:0] base, input int n);
        logic [N_MSG_W-1:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[N_MSG_W-1-k*16 -: 16] = base + 16'(k);
        return m;
    endfunction

    function automatic logic [W_MSG_W-1:0] mkw(input logic [31:0] base, input int n);
        logic [W_MSG_W-1:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[W_MSG_W-1-k*32 -: 32] = base + 32'(k);
        return m;
    endfunction

    // Present a message for one clock edge (caller ensures a slot is free).
    task automatic push_n(input logic [N_MSG_W-1:0] m, input logic [3:0] len);
        nb.v_msg_in = 1'b1;
        nb.msg_in   = m;
        nb.msg_len  = len;
        @(negedge clk);
        nb.v_msg_in = 1'b0;
    endtask

    task automatic push_w(input logic [W_MSG_W-1:0] m, input logic [1:0] len);
        wb.v_msg_in = 1'b1;
        wb.msg_in   = m;
        wb.msg_len  = len;
        @(negedge clk);
        wb.v_msg_in = 1'b0;
    endtask

    // One cycle of the narrow DUT: check outputs, then advance to next falling edge.
    task automatic cyc(input string tag, input logic ev, input logic [15:0] ef,
                       input logic [1:0] ec, input logic er);
        #1;
        check_val({tag, "_v"}, 64'(nb.v_flit_out), 64'(ev));
        if (ev) check_val({tag, "_flit"}, 64'(nb.flit_out), 64'(ef));
        check_val({tag, "_ctrl"}, 64'(nb.ctrl_out), 64'(ec));
        check_val({tag, "_rdy"}, 64'(nb.msg_in_rdy), 64'(er));
        @(negedge clk);
    endtask

    // Expect n consecutive flits base..base+n-1 with fifo_rdy held high, then idle.
    task automatic drain_n(input string tag, input logic [15:0] base, input int n);
        logic [1:0] c;
        #1 check_val({tag, "_busy"}, 64'(nb.busy), 64'd1);
        for (int k = 0; k < n; k++) begin
            c = (k == n - 1) ? CTRL_TAIL : ((k == 0) ? CTRL_HEAD : CTRL_BODY);
            cyc($sformatf("%s_f%0d", tag, k), 1'b1, base + 16'(k), c, 1'b1);
        end
        #1;
        check_val({tag, "_idle_v"}, 64'(nb.v_flit_out), 64'd0);
        check_val({tag, "_idle_ctrl"}, 64'(nb.ctrl_out), 64'(CTRL_IDLE));
        check_val({tag, "_idle_busy"}, 64'(nb.busy), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wflit [7];
        logic [1:0]  wctrl [7];

        nb.v_msg_in = 1'b0; nb.msg_in = '0; nb.msg_len = '0; nb.fifo_rdy = 1'b1;
        wb.v_msg_in = 1'b0; wb.msg_in = '0; wb.msg_len = '0; wb.fifo_rdy = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state, both configurations.
        #1;
        check_val("rst_rdy", 64'(nb.msg_in_rdy), 64'd1);
        check_val("rst_v", 64'(nb.v_flit_out), 64'd0);
        check_val("rst_ctrl", 64'(nb.ctrl_out), 64'(CTRL_IDLE));
        check_val("rst_flit", 64'(nb.flit_out), 64'd0);
        check_val("rst_busy", 64'(nb.busy), 64'd0);
        check_val("wrst_rdy", 64'(wb.msg_in_rdy), 64'd1);
        check_val("wrst_v", 64'(wb.v_flit_out), 64'd0);
        check_val("wrst_flit", 64'(wb.flit_out), 64'd0);
        check_val("wrst_busy", 64'(wb.busy), 64'd0);
        @(negedge clk);

        // T1: 9-flit message, A000..A008.
        push_n(mkn(16'hA000, 9), 4'd8);
        drain_n("t1", 16'hA000, 9);

        // T2: single-flit message goes out as a tail.
        push_n(mkn(16'h1234, 1), 4'd0);
        drain_n("t2", 16'h1234, 1);

        // T3: fill both slots with the ring stalled; third message held by source.
        nb.fifo_rdy = 1'b0;
        push_n(mkn(16'hB000, 3), 4'd2);
        push_n(mkn(16'hC000, 2), 4'd1);
        nb.v_msg_in = 1'b1; nb.msg_in = mkn(16'hD000, 1); nb.msg_len = 4'd0;
        #1 check_val("t3_busy", 64'(nb.busy), 64'd1);
        cyc("t3_full0", 1'b0, 16'h0, CTRL_IDLE, 1'b0);
        cyc("t3_full1", 1'b0, 16'h0, CTRL_IDLE, 1'b0);
        nb.fifo_rdy = 1'b1;
        cyc("t3_b0", 1'b1, 16'hB000, CTRL_HEAD, 1'b0);
        cyc("t3_b1", 1'b1, 16'hB001, CTRL_BODY, 1'b0);
        cyc("t3_b2", 1'b1, 16'hB002, CTRL_TAIL, 1'b0);
        cyc("t3_c0", 1'b1, 16'hC000, CTRL_HEAD, 1'b1);
        nb.v_msg_in = 1'b0;
        cyc("t3_c1", 1'b1, 16'hC001, CTRL_TAIL, 1'b0);
        cyc("t3_d0", 1'b1, 16'hD000, CTRL_TAIL, 1'b1);
        cyc("t3_idle", 1'b0, 16'h0, CTRL_IDLE, 1'b1);

        // T4: 4-flit message with fifo_rdy toggling.
        push_n(mkn(16'hE000, 4), 4'd3);
        for (int k = 0; k < 4; k++) begin
            nb.fifo_rdy = 1'b1;
            cyc($sformatf("t4_f%0d", k), 1'b1, 16'hE000 + 16'(k),
                (k == 0) ? CTRL_HEAD : ((k == 3) ? CTRL_TAIL : CTRL_BODY), 1'b1);
            nb.fifo_rdy = 1'b0;
            cyc($sformatf("t4_stall%0d", k), 1'b0, 16'h0, CTRL_IDLE, 1'b1);
        end
        nb.fifo_rdy = 1'b1;
        #1 check_val("t4_busy", 64'(nb.busy), 64'd0);
        @(negedge clk);

        // T5: reset mid-message with a second message buffered.
        push_n(mkn(16'hF000, 9), 4'd8);
        nb.v_msg_in = 1'b1; nb.msg_in = mkn(16'h5000, 2); nb.msg_len = 4'd1;
        cyc("t5_f0", 1'b1, 16'hF000, CTRL_HEAD, 1'b1);
        nb.v_msg_in = 1'b0;
        cyc("t5_f1", 1'b1, 16'hF001, CTRL_BODY, 1'b0);
        cyc("t5_f2", 1'b1, 16'hF002, CTRL_BODY, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("t5_busy", 64'(nb.busy), 64'd0);
        check_val("t5_rdy", 64'(nb.msg_in_rdy), 64'd1);
        check_val("t5_v", 64'(nb.v_flit_out), 64'd0);
        @(negedge clk);
        push_n(mkn(16'h7700, 2), 4'd1);
        drain_n("t5_new", 16'h7700, 2);

        // T6: msg_len 12 clamps to 9 flits.
        push_n(mkn(16'h9000, 9), 4'd12);
        drain_n("t6", 16'h9000, 9);

        // Wide configuration: fill all 4 slots while stalled, then drain.
        wb.fifo_rdy = 1'b0;
        push_w(mkw(32'hA000_0000, 4), 2'd3);
        #1 check_val("w_rdy1", 64'(wb.msg_in_rdy), 64'd1);
        for (int i = 1; i < 4; i++) begin
            push_w(mkw(32'hB000_0000 + 32'(i), 1), 2'd0);
            #1 check_val($sformatf("w_rdy%0d", i + 1), 64'(wb.msg_in_rdy), 64'(i < 3));
        end
        check_val("w_stall_v", 64'(wb.v_flit_out), 64'd0);
        check_val("w_stall_ctrl", 64'(wb.ctrl_out), 64'(CTRL_IDLE));
        check_val("w_stall_busy", 64'(wb.busy), 64'd1);
        for (int k = 0; k < 4; k++) begin
            wflit[k] = 32'hA000_0000 + 32'(k);
            wctrl[k] = (k == 0) ? CTRL_HEAD : ((k == 3) ? CTRL_TAIL : CTRL_BODY);
        end
        for (int i = 1; i < 4; i++) begin
            wflit[3+i] = 32'hB000_0000 + 32'(i);
            wctrl[3+i] = CTRL_TAIL;
        end
        @(negedge clk);
        wb.fifo_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            check_val($sformatf("w%0d_v", k), 64'(wb.v_flit_out), 64'd1);
            check_val($sformatf("w%0d_flit", k), 64'(wb.flit_out), 64'(wflit[k]));
            check_val($sformatf("w%0d_ctrl", k), 64'(wb.ctrl_out), 64'(wctrl[k]));
            check_val($sformatf("w%0d_rdy", k), 64'(wb.msg_in_rdy), 64'(k >= 4));
            @(negedge clk);
        end
        #1;
        check_val("w_idle_v", 64'(wb.v_flit_out), 64'd0);
        check_val("w_idle_busy", 64'(wb.busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule : tb_m_upload_serializer
